// File: rtl/ram_sdp_be_clr_if.sv
// Port bundle for ram_sdp_be_clr: write, read and clear requests
// from the master; read data, valid strobe and busy from the RAM.
interface ram_sdp_be_clr_if #(
  parameter int AWIDTH = 3,
  parameter int DWIDTH = 32
);
  localparam int NBYTES = DWIDTH / 8;

  logic              we;
  logic [AWIDTH-1:0] waddr;
  logic [DWIDTH-1:0] din;
  logic [NBYTES-1:0] be;
  logic              re;
  logic [AWIDTH-1:0] raddr;
  logic              clr;
  logic [DWIDTH-1:0] dout;
  logic              dout_valid;
  logic              busy;

  modport master (
    output we, waddr, din, be,
    output re, raddr, clr,
    input  dout, dout_valid, busy
  );

  modport slave (
    input  we, waddr, din, be,
    input  re, raddr, clr,
    output dout, dout_valid, busy
  );
endinterface

// File: rtl/ram_sdp_be_clr.sv
// Simple-dual-port RAM with byte-enable writes, registered reads
// and a clear engine that zero-fills the array after reset or clr.
module ram_sdp_be_clr #(
  parameter int AWIDTH     = 3,
  parameter int DWIDTH     = 32,
  parameter bit OUT_REG    = 1'b0,
  parameter bit WR_THRU    = 1'b0,
  parameter bit CLR_ON_RST = 1'b1
) (
  input  logic           clock,
  input  logic           reset_n,
  ram_sdp_be_clr_if.slave bus
);
  localparam int DEPTH  = 1 << AWIDTH;
  localparam int NBYTES = DWIDTH / 8;
  localparam logic [AWIDTH-1:0] LAST = AWIDTH'(DEPTH - 1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state, state_nxt;
  logic [AWIDTH-1:0] clr_addr, clr_addr_nxt;
  logic [DWIDTH-1:0] mem [DEPTH];
  logic [DWIDTH-1:0] old_data, merged, rd_sel;
  logic [DWIDTH-1:0] rd_data;
  logic              rd_valid;
  logic              run, wr_ok, rd_ok;

  assign run      = (state == RUN);
  assign bus.busy = ~run;
  assign wr_ok    = bus.we & run;
  assign rd_ok    = bus.re & run;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= CLR_ON_RST ? CLEAR : RUN;
      clr_addr <= '0;
    end else begin
      state    <= state_nxt;
      clr_addr <= clr_addr_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    clr_addr_nxt = clr_addr;
    unique case (state)
      CLEAR: begin
        clr_addr_nxt = clr_addr + AWIDTH'(1);
        if (clr_addr == LAST) begin
          state_nxt    = RUN;
          clr_addr_nxt = '0;
        end
      end
      RUN: begin
        if (bus.clr) state_nxt = CLEAR;
      end
      default: state_nxt = state;
    endcase
  end

  // Array has no reset; the clear engine owns it while busy.
  always_ff @(posedge clock) begin
    if (!run) begin
      mem[clr_addr] <= '0;
    end else if (wr_ok) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (bus.be[i]) begin
          mem[bus.waddr][8*i +: 8] <= bus.din[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    old_data = mem[bus.raddr];
    merged   = old_data;
    for (int i = 0; i < NBYTES; i++) begin
      if (bus.be[i]) merged[8*i +: 8] = bus.din[8*i +: 8];
    end
    rd_sel = old_data;
    if (WR_THRU && bus.we && (bus.waddr == bus.raddr)) begin
      rd_sel = merged;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_ok;
      if (rd_ok) rd_data <= rd_sel;
    end
  end

  generate
    if (OUT_REG) begin : g_oreg
      logic [DWIDTH-1:0] q;
      logic              v;

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          q <= '0;
          v <= 1'b0;
        end else begin
          v <= rd_valid;
          if (rd_valid) q <= rd_data;
        end
      end

      assign bus.dout       = q;
      assign bus.dout_valid = v;
    end else begin : g_direct
      assign bus.dout       = rd_data;
      assign bus.dout_valid = rd_valid;
    end
  endgenerate
endmodule

// File: tb/tb_ram_sdp_be_clr.sv
// Scoreboard bench: three RAM variants (plain, write-through,
// output register) driven in lockstep and checked against a model.
module tb_ram_sdp_be_clr;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we = 1'b0, re = 1'b0, clr = 1'b0;
  logic [2:0]  waddr = '0, raddr = '0;
  logic [31:0] din = '0;
  logic [3:0]  be = '0;
  int          cyc = 0;
  int          checks = 0;
  int          fails = 0;

  typedef struct {
    logic [31:0] d;
    int          due;
  } exp_t;

  exp_t        q0[$], q1[$], q2[$];
  exp_t        e0, e1, e2;
  logic [31:0] mdl [8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_sdp_be_clr_if #(.AWIDTH(3), .DWIDTH(32)) b0 ();
  ram_sdp_be_clr_if #(.AWIDTH(3), .DWIDTH(32)) b1 ();
  ram_sdp_be_clr_if #(.AWIDTH(3), .DWIDTH(32)) b2 ();

  assign b0.we = we;  assign b1.we = we;  assign b2.we = we;
  assign b0.re = re;  assign b1.re = re;  assign b2.re = re;
  assign b0.clr = clr; assign b1.clr = clr; assign b2.clr = clr;
  assign b0.waddr = waddr; assign b1.waddr = waddr; assign b2.waddr = waddr;
  assign b0.raddr = raddr; assign b1.raddr = raddr; assign b2.raddr = raddr;
  assign b0.din = din; assign b1.din = din; assign b2.din = din;
  assign b0.be = be;  assign b1.be = be;  assign b2.be = be;

  ram_sdp_be_clr #(
    .AWIDTH(3), .DWIDTH(32), .OUT_REG(1'b0),
    .WR_THRU(1'b0), .CLR_ON_RST(1'b1)
  ) u0 (.clock(clk), .reset_n(rst_n), .bus(b0));

  ram_sdp_be_clr #(
    .AWIDTH(3), .DWIDTH(32), .OUT_REG(1'b0),
    .WR_THRU(1'b1), .CLR_ON_RST(1'b1)
  ) u1 (.clock(clk), .reset_n(rst_n), .bus(b1));

  ram_sdp_be_clr #(
    .AWIDTH(3), .DWIDTH(32), .OUT_REG(1'b1),
    .WR_THRU(1'b0), .CLR_ON_RST(1'b1)
  ) u2 (.clock(clk), .reset_n(rst_n), .bus(b2));

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(logic [31:0] o,
                                        logic [31:0] d,
                                        logic [3:0]  b);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) r[8*i +: 8] = d[8*i +: 8];
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst_n && b0.dout_valid) begin
      if (q0.size() == 0) begin
        chk("u0 unexpected valid", 32'd1, 32'd0);
      end else begin
        e0 = q0.pop_front();
        chk("u0 dout", b0.dout, e0.d);
        chk("u0 latency", cyc, e0.due);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && b1.dout_valid) begin
      if (q1.size() == 0) begin
        chk("u1 unexpected valid", 32'd1, 32'd0);
      end else begin
        e1 = q1.pop_front();
        chk("u1 dout", b1.dout, e1.d);
        chk("u1 latency", cyc, e1.due);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && b2.dout_valid) begin
      if (q2.size() == 0) begin
        chk("u2 unexpected valid", 32'd1, 32'd0);
      end else begin
        e2 = q2.pop_front();
        chk("u2 dout", b2.dout, e2.d);
        chk("u2 latency", cyc, e2.due);
      end
    end
  end

  task automatic op(bit w, logic [2:0] wa, logic [31:0] d,
                    logic [3:0] b, bit r, logic [2:0] ra, bit c);
    logic [31:0] old, thru;
    old  = mdl[ra];
    thru = (w && wa == ra) ? merge(old, d, b) : old;
    if (r) begin
      q0.push_back('{old, cyc + 1});
      q1.push_back('{thru, cyc + 1});
      q2.push_back('{old, cyc + 2});
    end
    if (w) mdl[wa] = merge(mdl[wa], d, b);
    if (c) foreach (mdl[i]) mdl[i] = '0;
    we = w; waddr = wa; din = d; be = b;
    re = r; raddr = ra; clr = c;
    @(posedge clk); #1;
    we = 1'b0; re = 1'b0; clr = 1'b0;
  endtask

  task automatic rd(logic [2:0] a);
    op(1'b0, 3'd0, 32'd0, 4'd0, 1'b1, a, 1'b0);
  endtask

  task automatic wr(logic [2:0] a, logic [31:0] d, logic [3:0] b);
    op(1'b1, a, d, b, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin
      op(1'b0, 3'd0, 32'd0, 4'd0, 1'b0, 3'd0, 1'b0);
    end
  endtask

  task automatic reset_vals(string tag);
    chk({tag, " u0 dout"}, b0.dout, 32'd0);
    chk({tag, " u1 dout"}, b1.dout, 32'd0);
    chk({tag, " u2 dout"}, b2.dout, 32'd0);
    chk({tag, " u0 valid"}, 32'(b0.dout_valid), 32'd0);
    chk({tag, " u1 valid"}, 32'(b1.dout_valid), 32'd0);
    chk({tag, " u2 valid"}, 32'(b2.dout_valid), 32'd0);
    chk({tag, " u0 busy"}, 32'(b0.busy), 32'd1);
    chk({tag, " u1 busy"}, 32'(b1.busy), 32'd1);
    chk({tag, " u2 busy"}, 32'(b2.busy), 32'd1);
  endtask

  task automatic count_busy(string tag);
    int n0, n1, n2;
    n0 = 0; n1 = 0; n2 = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n0 += int'(b0.busy);
      n1 += int'(b1.busy);
      n2 += int'(b2.busy);
    end
    chk({tag, " u0 busy cycles"}, n0, 32'd8);
    chk({tag, " u1 busy cycles"}, n1, 32'd8);
    chk({tag, " u2 busy cycles"}, n2, 32'd8);
  endtask

  task automatic release_rst();
    @(posedge clk); #1;
    rst_n = 1'b1;
    foreach (mdl[i]) mdl[i] = '0;
  endtask

  initial begin
    foreach (mdl[i]) mdl[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_vals("reset");

    release_rst();
    count_busy("post-reset");
    for (int a = 0; a < 8; a++) begin
      rd(3'(a));
      idle(1);
    end
    idle(2);

    wr(3'd2, 32'hFFFF_FFFF, 4'b1111);
    wr(3'd2, 32'h1234_5678, 4'b0101);
    rd(3'd2);
    op(1'b1, 3'd2, 32'h0, 4'b0000, 1'b0, 3'd0, 1'b0);
    rd(3'd2);
    idle(2);

    wr(3'd5, 32'hAAAA_AAAA, 4'b1111);
    op(1'b1, 3'd5, 32'h5555_5555, 4'b1111, 1'b1, 3'd5, 1'b0);
    rd(3'd5);
    op(1'b1, 3'd5, 32'h1111_1111, 4'b0011, 1'b1, 3'd5, 1'b0);
    rd(3'd5);
    idle(2);

    for (int a = 0; a < 4; a++) wr(3'(a), 32'(10 + a), 4'b1111);
    for (int a = 0; a < 4; a++) rd(3'(a));
    idle(3);

    wr(3'd1, 32'd7, 4'b1111);
    rd(3'd1);
    op(1'b0, 3'd0, 32'd0, 4'd0, 1'b1, 3'd1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      we = 1'b1; waddr = 3'd1; din = 32'hDEAD_BEEF; be = 4'b1111;
      re = 1'b1; raddr = 3'd1;
      @(negedge clk);
      chk("clear busy u0", 32'(b0.busy), 32'd1);
      chk("clear busy u2", 32'(b2.busy), 32'd1);
      @(posedge clk); #1;
    end
    we = 1'b0; re = 1'b0;
    @(negedge clk);
    chk("clear done u0", 32'(b0.busy), 32'd0);
    chk("clear done u1", 32'(b1.busy), 32'd0);
    rd(3'd1);
    for (int a = 0; a < 8; a++) rd(3'(a));
    idle(3);

    wr(3'd3, 32'h0000_0099, 4'b1111);
    rd(3'd3);
    op(1'b0, 3'd0, 32'd0, 4'd0, 1'b0, 3'd0, 1'b1);
    idle(3);
    chk("pre-reset u2 dout", b2.dout, 32'h99);
    chk("q0 drained", q0.size(), 32'd0);
    chk("q1 drained", q1.size(), 32'd0);
    chk("q2 drained", q2.size(), 32'd0);
    rst_n = 1'b0;
    #1;
    reset_vals("mid-clear reset");
    q0.delete(); q1.delete(); q2.delete();
    @(posedge clk);
    release_rst();
    count_busy("re-clear");
    for (int a = 0; a < 8; a++) rd(3'(a));
    idle(4);

    chk("q0 empty", q0.size(), 32'd0);
    chk("q1 empty", q1.size(), 32'd0);
    chk("q2 empty", q2.size(), 32'd0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule

// File: doc/ram_sdp_be_clr.md
# ram_sdp_be_clr

Parametrised simple-dual-port synchronous-read RAM: one write port with byte enables, one independent read port with registered output and valid flag. Optional output pipeline stage and write-through collision mode. After reset, or on a soft-clear request, a built-in clear engine zero-fills the array. Drop-in successor for the single-port synchronous-read data RAMs in the datapath, for buffers that need concurrent read and write plus a known-zero start state.

## Interface
- AWIDTH, 3, address width; DEPTH = 1 << AWIDTH
- DWIDTH, 32, data width; must be a multiple of 8; NBYTES = DWIDTH/8
- OUT_REG, 0, 1 adds an output register stage, making read latency 2
- WR_THRU, 0, read/write same-address collision: 0 returns old data, 1 returns new merged data
- CLR_ON_RST, 1, 1 runs the clear engine after reset; 0 skips it

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- we  in  1  write request
- waddr  in  AWIDTH  write address
- din  in  DWIDTH  write data
- be  in  NBYTES  byte enables; be[i] covers din[8i+7:8i]
- re  in  1  read request
- raddr  in  AWIDTH  read address
- clr  in  1  soft-clear request (single-cycle pulse)
- dout  out  DWIDTH  read data, registered, held between reads
- dout_valid  out  1  one-cycle strobe marking new dout
- busy  out  1  clear engine active; requests ignored

## Operation
- FSM states: CLEAR, RUN.
- Reset (reset_n low): state = CLEAR if CLR_ON_RST=1, else RUN. clr_addr=0, dout=0, dout_valid=0, pipeline valids=0. busy = 1 if CLR_ON_RST else 0. Array contents are not reset by reset_n.
- CLEAR: each edge writes 0 to mem[clr_addr] and increments clr_addr. The edge that writes DEPTH-1 moves state to RUN and resets clr_addr to 0. busy = (state==CLEAR).
- RUN, clr=1 at an edge: state goes to CLEAR. we/re sampled on that same edge are still serviced.
- clr during CLEAR: ignored; the clear runs to completion once.
- we/re sampled while busy=1: dropped. There is no write and no dout_valid.
- Write in RUN, we=1: for each i with be[i]=1, mem[waddr] byte i <= din byte i. Other bytes are unchanged. we=1 with be=0 is a no-op.
- Read in RUN, re=1: data from mem[raddr] is captured into the read register.
- Collision, re & we & raddr==waddr:
  - WR_THRU=0: old contents are returned.
  - WR_THRU=1: bytes with be=1 come from din; other bytes come from old contents.
- dout holds its last value when no read completes.
- Reads accepted before a clr edge complete normally, with pre-clear data.

## Timing
- OUT_REG=0: re at edge N gives dout and dout_valid=1 after edge N. Valid for exactly one cycle unless re was high again at edge N+1.
- OUT_REG=1: same behaviour one edge later, at N+1. Back-to-back reads give one result per cycle, with no bubbles.
- Write is visible to a read sampled at the edge after the write edge.
- Clear engine: busy high for exactly DEPTH cycles after reset deassertion or after the clr edge. The first request is accepted at the edge where busy is low.
- Reset asserted mid-clear or mid-read: all outputs return to reset values immediately. The clear restarts at address 0 after release. Partially cleared contents are overwritten.
- reset_n deassertion must be synchronous to clock (external synchroniser).

## Test plan
- Reset with CLR_ON_RST=1, AWIDTH=3:
  - busy=1 for 8 cycles, then 0.
  - Reads of all 8 addresses return 0, each with a single dout_valid pulse one cycle later.
- Byte-enable write: write 0xFFFFFFFF to addr 2, then din=0x12345678 with be=4'b0101 -> read addr 2 returns 0xFF34FF78.
- Collision at addr 5, old value 0xAAAAAAAA, din=0x55555555, be=4'b1111 -> WR_THRU=0 returns 0xAAAAAAAA, WR_THRU=1 returns 0x55555555. A following read returns 0x55555555.
- OUT_REG=1 streaming: re high for 4 cycles over addrs 0..3 holding 10,11,12,13 -> dout_valid high for 4 consecutive cycles starting 2 edges after the first re, dout = 10,11,12,13.
- Soft clear with reads in flight:
  - clr pulse while a read of addr 1 (value 7) is in flight -> read returns 7.
  - busy=1 for DEPTH cycles. we/re during busy are dropped (no dout_valid, no write).
  - Addr 1 reads 0 afterwards.
- Reset mid-clear at cycle 3 of CLEAR: dout=0 and dout_valid=0 asynchronously. After release, busy=1 for a full DEPTH cycles and all addresses read 0.
